// File: rtl/jtgng_ps2_tx_pkg.sv
// Shared PS/2 command bytes and the odd-parity helper used by the host transmit path.
package jtgng_ps2_tx_pkg;

  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_CMD_LEDS   = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
  localparam logic [7:0] PS2_ACK_BYTE   = 8'hFA;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/jtgng_ps2_sync.sv
// Two-flop synchronizers for both PS/2 lines plus a falling-edge strobe on the clock line.
module jtgng_ps2_sync (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic [1:0] clk_ff;
  logic [1:0] data_ff;
  logic       clk_prev;

  // Idle bus level is high, so presetting to 1 avoids a spurious edge out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_ff   <= 2'b11;
      data_ff  <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_ff   <= {clk_ff[0], ps2_clk_in};
      data_ff  <= {data_ff[0], ps2_data_in};
      clk_prev <= clk_ff[1];
    end
  end

  assign clk_sync  = clk_ff[1];
  assign data_sync = data_ff[1];
  assign clk_fall  = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/jtgng_ps2_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 8 data bits LSB first, odd parity,
// stop bit, device ACK check and bus-release wait, with an inter-edge timeout.
module jtgng_ps2_tx #(
  parameter int INHIBIT = 4800,
  parameter int TIMEOUT = 720000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_req,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);
  import jtgng_ps2_tx_pkg::*;

  localparam int CNT_MAX = (INHIBIT > TIMEOUT) ? INHIBIT : TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT - 1);
  localparam logic [CW-1:0] INHIBIT_DATA = CW'(INHIBIT - 2);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_INHIBIT = 3'd1;
  localparam logic [2:0] ST_RTS     = 3'd2;
  localparam logic [2:0] ST_BITS    = 3'd3;
  localparam logic [2:0] ST_ACK     = 3'd4;
  localparam logic [2:0] ST_WAITREL = 3'd5;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    data;
  logic          parity;
  logic [2:0]    next_bit;

  logic clk_sync;
  logic data_sync;
  logic clk_fall;

  jtgng_ps2_sync u_sync (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .clk_sync    (clk_sync),
    .data_sync   (data_sync),
    .clk_fall    (clk_fall)
  );

  // bit_cnt holds the index of the bit currently on the wire (8 = parity).
  assign next_bit = bit_cnt[2:0] + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      data        <= '0;
      parity      <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          ps2_clk_oe  <= 1'b0;
          ps2_data_oe <= 1'b0;
          if (tx_req) begin
            data       <= tx_data;
            parity     <= odd_parity(tx_data);
            cnt        <= '0;
            ps2_clk_oe <= 1'b1;
            tx_busy    <= 1'b1;
            state      <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          cnt <= cnt + CW'(1);
          if (cnt == INHIBIT_DATA) ps2_data_oe <= 1'b1;
          if (cnt == INHIBIT_LAST) begin
            ps2_clk_oe <= 1'b0;
            cnt        <= '0;
            state      <= ST_RTS;
          end
        end
        default: begin
          if (clk_fall) cnt <= '0;
          else          cnt <= cnt + CW'(1);
          if (!clk_fall && cnt == TIMEOUT_LAST) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_err      <= 1'b1;
            tx_busy     <= 1'b0;
            cnt         <= '0;
            state       <= ST_IDLE;
          end else begin
            case (state)
              ST_RTS: if (clk_fall) begin
                ps2_data_oe <= ~data[0];
                bit_cnt     <= '0;
                state       <= ST_BITS;
              end
              ST_BITS: if (clk_fall) begin
                if (bit_cnt < 4'd7) begin
                  ps2_data_oe <= ~data[next_bit];
                  bit_cnt     <= bit_cnt + 4'd1;
                end else if (bit_cnt == 4'd7) begin
                  ps2_data_oe <= ~parity;
                  bit_cnt     <= 4'd8;
                end else begin
                  ps2_data_oe <= 1'b0;
                  state       <= ST_ACK;
                end
              end
              ST_ACK: if (clk_fall) begin
                if (!data_sync) begin
                  state <= ST_WAITREL;
                end else begin
                  tx_err  <= 1'b1;
                  tx_busy <= 1'b0;
                  state   <= ST_IDLE;
                end
              end
              ST_WAITREL: if (clk_sync && data_sync) begin
                tx_done <= 1'b1;
                tx_busy <= 1'b0;
                state   <= ST_IDLE;
              end
              default: state <= ST_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtgng_ps2_tx.sv
// Scoreboarded bench: a device model clocks frames out of the DUT, a monitor checks each outcome.
module tb_jtgng_ps2_tx;

  localparam int INH  = 8;
  localparam int TO   = 200;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_req = 1'b0;
  logic       tx_busy, tx_done, tx_err;

  always #5 clk = ~clk;

  // Open-drain wired-AND of host and device drivers.
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  jtgng_ps2_tx #(.INHIBIT(INH), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .tx_data     (tx_data),
    .tx_req      (tx_req),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_err      (tx_err)
  );

  typedef struct {
    bit          is_done;
    bit          has_frame;
    logic [10:0] frame;
    logic [7:0]  data;
  } exp_t;

  exp_t        exp_q[$];
  logic [10:0] cap_frame = '0;
  int          vectors = 0;
  int          miscompares = 0;
  int          txn_id = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Wire frame as the device sees it: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] ref_frame(input logic [7:0] d);
    logic par;
    par = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, d, 1'b0};
  endfunction

  // Monitor: every done/err pulse consumes one expected outcome.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (tx_done || tx_err) begin
        check("done_err_exclusive", {31'd0, tx_done & tx_err}, 32'd0);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_pulse: done=%0b err=%0b with no request outstanding", tx_done, tx_err);
        end else begin
          e = exp_q.pop_front();
          check("outcome_done", {31'd0, tx_done}, {31'd0, e.is_done});
          check("outcome_err", {31'd0, tx_err}, {31'd0, !e.is_done});
          check("busy_at_end", {31'd0, tx_busy}, 32'd0);
          if (e.has_frame) check("wire_frame", {21'd0, cap_frame}, {21'd0, e.frame});
          $display("txn %0d data=%02h done=%0b err=%0b frame=%03h", txn_id, e.data, tx_done, tx_err, cap_frame);
          txn_id++;
        end
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  // mode: 0 = ACK, 1 = no ACK, 2 = device silent, 3 = reset after edge 4
  task automatic send_req(input logic [7:0] d, input int mode);
    exp_t e;
    if (mode != 3) begin
      e.is_done   = (mode == 0);
      e.has_frame = (mode != 2);
      e.frame     = ref_frame(d);
      e.data      = d;
      exp_q.push_back(e);
    end
    tx_data = d;
    tx_req  = 1'b1;
    @(negedge clk);
    tx_req  = 1'b0;
    tx_data = 8'($urandom);
    check("busy_after_req", {31'd0, tx_busy}, 32'd1);
  endtask

  task automatic device_run(input int mode);
    int   n;
    logic first_d, last_d;
    n = 0;
    while (ps2_clk_oe !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("inhibit_start", {31'd0, ps2_clk_oe}, 32'd1);
    n = 0;
    first_d = ps2_data_oe;
    last_d  = 1'b0;
    while (ps2_clk_oe === 1'b1 && n < 100) begin
      last_d = ps2_data_oe;
      n++;
      @(negedge clk);
    end
    check("inhibit_len", n, INH);
    check("inhibit_data_early", {31'd0, first_d}, 32'd0);
    check("inhibit_data_last", {31'd0, last_d}, 32'd1);
    check("rts_start_bit", {31'd0, ps2_data_oe}, 32'd1);
    if (mode == 2) return;
    repeat (10) @(negedge clk);
    cap_frame[0] = ps2_data_in;
    for (int e = 1; e <= 11; e++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      if (mode == 3 && e == 4) return;
      dev_clk = 1'b1;
      if (e <= 10) cap_frame[e] = ps2_data_in;
      if (e == 10 && mode == 0) begin
        repeat (5) @(negedge clk);
        dev_data = 1'b0;
        repeat (HALF - 5) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
    dev_data = 1'b1;
  endtask

  task automatic finish_txn();
    int n;
    n = 0;
    while (tx_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("busy_released", {31'd0, tx_busy}, 32'd0);
    check("idle_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    check("idle_data_oe", {31'd0, ps2_data_oe}, 32'd0);
    repeat ($urandom_range(2, 10)) @(negedge clk);
  endtask

  task automatic run_txn(input logic [7:0] d, input int mode);
    int n;
    send_req(d, mode);
    device_run(mode);
    if (mode == 2) begin
      n = 0;
      while (!tx_err && n < 400) begin
        @(negedge clk);
        n++;
      end
      check("timeout_cycles", n, TO);
      check("timeout_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
      check("timeout_data_oe", {31'd0, ps2_data_oe}, 32'd0);
    end else if (mode == 3) begin
      tx_data = jtgng_ps2_tx_pkg::PS2_CMD_RESET;
      tx_req  = 1'b1;
      rst     = 1'b1;
      @(negedge clk);
      tx_req  = 1'b0;
      check("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
      check("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
      check("rst_busy", {31'd0, tx_busy}, 32'd0);
      dev_clk  = 1'b1;
      dev_data = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_req_dropped", {31'd0, tx_busy}, 32'd0);
    end
    finish_txn();
  endtask

  initial begin
    repeat (4) @(negedge clk);
    check("reset_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    check("reset_data_oe", {31'd0, ps2_data_oe}, 32'd0);
    check("reset_busy", {31'd0, tx_busy}, 32'd0);
    check("reset_done", {31'd0, tx_done}, 32'd0);
    check("reset_err", {31'd0, tx_err}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    run_txn(jtgng_ps2_tx_pkg::PS2_CMD_LEDS, 0);
    run_txn(8'h00, 0);
    run_txn(8'h01, 0);
    run_txn(8'hC3, 2);
    run_txn(jtgng_ps2_tx_pkg::PS2_CMD_ENABLE, 1);

    // A second request mid-transfer must not disturb the byte in flight.
    fork
      begin
        send_req(jtgng_ps2_tx_pkg::PS2_CMD_LEDS, 0);
        device_run(0);
      end
      begin
        repeat (150) @(negedge clk);
        check("busy_mid_transfer", {31'd0, tx_busy}, 32'd1);
        tx_data = jtgng_ps2_tx_pkg::PS2_CMD_RESET;
        tx_req  = 1'b1;
        @(negedge clk);
        tx_req  = 1'b0;
      end
    join
    finish_txn();

    run_txn(8'hAA, 3);

    for (int i = 0; i < 8; i++) begin
      run_txn(8'($urandom), ($urandom_range(0, 3) == 0) ? 1 : 0);
    end

    repeat (20) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
